a23_run_ctrl: RTL and testbench
===============================

A23_RUN_CTRL -- requirements
Module: a23_run_ctrl

Interface
REQ-001 SHALL have parameter OUT_MEM_SIZE, default 64: number of output words captured from the core.
REQ-002 SHALL have parameter WORD_W, default 32: width of one output word.
REQ-003 SHALL have parameter CC_W, default 32: width of the cycle counter.
REQ-004 SHALL have parameter RST_CYCLES, default 3: number of cycles the core is held in reset before each run (minimum 1).
REQ-005 SHALL have parameter MAX_CC, default 2**20: timeout limit in RUN cycles (used only with A23_RUN_TIMEOUT_EN).
REQ-006 SHALL have ports: clk  in  1  single clock; rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have ports: start  in  1  run request; abort  in  1  cancel the current run.
REQ-008 SHALL have ports: busy  out  1  run in progress; done  out  1  one-cycle completion pulse; timeout  out  1  last run hit MAX_CC.
REQ-009 SHALL have ports: core_rst  out  1  active-high reset to the core; core_terminate  in  1  core finished.
REQ-010 SHALL have ports: core_o  in  OUT_MEM_SIZE*WORD_W  flat core output memory, word i at bits [WORD_W*(i+1)-1 : WORD_W*i].
REQ-011 SHALL have ports: cc  out  CC_W  cycle count of the last run; rd_addr  in  clog2(OUT_MEM_SIZE)  snapshot index; rd_data  out  WORD_W  snapshot word.

Function
REQ-012 SHALL implement the states IDLE, RESET, RUN, CAPTURE and DONE.
REQ-013 IDLE: SHALL assert core_rst=1 and busy=0; start=1 SHALL move to RESET on the next edge, clear cc and clear timeout.
REQ-014 RESET: SHALL assert core_rst=1 for exactly RST_CYCLES cycles and then enter RUN; core_terminate SHALL be ignored in this state.
REQ-015 RUN: SHALL drive core_rst=0; cc SHALL increment in each RUN cycle in which core_terminate=0, saturating at all-ones.
REQ-016 RUN: core_terminate=1 SHALL move to CAPTURE with cc frozen; terminate high in the first RUN cycle SHALL give cc=0.
REQ-017 CAPTURE: SHALL hold core_rst=0 and copy word i of core_o into snapshot entry i in capture cycle i, for i=0..OUT_MEM_SIZE-1; CAPTURE SHALL last exactly OUT_MEM_SIZE cycles.
REQ-018 DONE: SHALL pulse done=1 for one cycle, then return to IDLE; busy SHALL be 1 in RESET, RUN and CAPTURE only.
REQ-019 rd_data SHALL be a combinational read of the snapshot at rd_addr, SHALL hold its value until the next CAPTURE overwrites it, and SHALL be undefined when rd_addr >= OUT_MEM_SIZE.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 abort=1 in RESET, RUN or CAPTURE SHALL go to IDLE on the next edge with no done pulse, cc frozen, and snapshot entries already written kept.
REQ-022 abort and start both high in IDLE: abort SHALL win and the block SHALL stay in IDLE.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state=IDLE, core_rst=1, busy=0, done=0, timeout=0 and cc=0.
REQ-024 The snapshot SHALL NOT be reset; rd_data SHALL be undefined until the first completed CAPTURE.
REQ-025 Reset asserted mid-run SHALL behave exactly as REQ-023, with no done pulse.

Configuration
REQ-026 With A23_RUN_TIMEOUT_EN defined, RUN SHALL move to CAPTURE and set timeout=1 when cc reaches MAX_CC with core_terminate=0; timeout SHALL stay set until the next start.
REQ-027 With A23_RUN_TIMEOUT_EN defined, core_terminate=1 in the same cycle cc reaches MAX_CC SHALL count as normal termination with timeout=0.
REQ-028 Without A23_RUN_TIMEOUT_EN, RUN SHALL wait indefinitely, the timeout output SHALL be tied to 0, and MAX_CC SHALL be unused.

Structure
REQ-029 Package a23_run_pkg SHALL hold the state enum typedef and the default values of RST_CYCLES and MAX_CC.
REQ-030 A sub-module a23_cycle_counter SHALL implement the saturating, clearable, enabled CC_W counter; all other logic SHALL stay in a23_run_ctrl.

Verification
REQ-031 Normal run: OUT_MEM_SIZE=4, RST_CYCLES=3, start pulse, core_terminate raised 10 RUN cycles after RUN entry with core_o words 0x11,0x22,0x33,0x44 -> core_rst high for 3 cycles; cc=10; done pulses 4 cycles after terminate; rd_addr=2 gives 0x33.
REQ-032 Immediate terminate: core_terminate already high when RUN is entered -> cc=0 and capture proceeds normally.
REQ-033 Timeout (macro defined, MAX_CC=16, terminate never raised) -> timeout=1, cc=16, done pulses; a second start clears timeout to 0.
REQ-034 Abort in RUN after 5 cycles -> IDLE next cycle, core_rst=1, no done pulse, cc=5, previous snapshot unchanged.
REQ-035 Asynchronous reset pulsed mid-CAPTURE -> all outputs at reset values immediately, no done pulse; a subsequent start completes a normal run.
REQ-036 start held high through an entire run -> exactly one run per rising start in IDLE; start during busy is ignored.

Source files
------------

// File: rtl/a23_run_pkg.sv
// Shared types and parameter defaults for the a23 run controller.
package a23_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_RUN     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } run_state_e;

  localparam int unsigned RST_CYCLES_DEF = 3;
  localparam int unsigned MAX_CC_DEF     = 2**20;

  // Index width that stays legal for single-entry memories.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/a23_cycle_counter.sv
// Saturating, clearable, enabled cycle counter.
module a23_cycle_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear beats enable; hold at all-ones once reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/a23_run_ctrl.sv
// Run controller: resets the core, times a run, snapshots its output memory.
// Optional RUN timeout enabled by defining A23_RUN_TIMEOUT_EN.
module a23_run_ctrl
  import a23_run_pkg::*;
#(
  parameter int unsigned OUT_MEM_SIZE = 64,
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned CC_W         = 32,
  parameter int unsigned RST_CYCLES   = RST_CYCLES_DEF,
  parameter int unsigned MAX_CC       = MAX_CC_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic                           core_rst,
  input  logic                           core_terminate,
  input  logic [OUT_MEM_SIZE*WORD_W-1:0] core_o,
  output logic [CC_W-1:0]                cc,
  input  logic [idx_w(OUT_MEM_SIZE)-1:0] rd_addr,
  output logic [WORD_W-1:0]              rd_data
);

  localparam int unsigned AW    = idx_w(OUT_MEM_SIZE);
  localparam int unsigned CNT_W = idx_w((OUT_MEM_SIZE > RST_CYCLES) ? OUT_MEM_SIZE : RST_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(OUT_MEM_SIZE - 1);

`ifdef A23_RUN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  run_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic              core_rst_q, core_rst_d;
  logic              done_q, done_d;
  logic              start_q;
  logic              start_rise;
  logic              tmo_hit;
  logic              cc_clr, cc_en;
  logic              snap_we;

  logic [WORD_W-1:0] core_w [OUT_MEM_SIZE];
  logic [WORD_W-1:0] snap_q [OUT_MEM_SIZE];

  for (genvar g = 0; g < OUT_MEM_SIZE; g++) begin : g_word
    assign core_w[g] = core_o[g*WORD_W +: WORD_W];
  end

  // A held start launches only one run: act on its rising edge.
  assign start_rise = start & ~start_q;
  assign tmo_hit    = TMO_EN && (cc == CC_W'(MAX_CC));

  a23_cycle_counter #(
    .W (CC_W)
  ) u_cc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cc_clr),
    .en_i  (cc_en),
    .cnt_o (cc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
      busy_q     <= busy_d;
      core_rst_q <= core_rst_d;
      done_q     <= done_d;
      start_q    <= start;
    end
  end

  // Next state; the phase counter restarts from zero on every state change.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    timeout_d = timeout_q;
    cc_clr    = 1'b0;
    cc_en     = 1'b0;
    snap_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_rise && !abort) begin
          state_d   = ST_RESET;
          timeout_d = 1'b0;
          cc_clr    = 1'b1;
        end
      end
      ST_RESET: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (core_terminate) begin
          state_d = ST_CAPTURE;
        end else if (tmo_hit) begin
          state_d   = ST_CAPTURE;
          timeout_d = 1'b1;
        end else begin
          cc_en = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          snap_we = 1'b1;
          if (cnt_q == CAP_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the next state so they register alongside it.
  always_comb begin
    busy_d     = 1'b0;
    core_rst_d = 1'b1;
    done_d     = 1'b0;
    case (state_d)
      ST_RESET: busy_d = 1'b1;
      ST_RUN, ST_CAPTURE: begin
        busy_d     = 1'b1;
        core_rst_d = 1'b0;
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  // Snapshot is deliberately not reset.
  always_ff @(posedge clk) begin
    if (snap_we) begin
      snap_q[cnt_q[AW-1:0]] <= core_w[cnt_q[AW-1:0]];
    end
  end

  assign rd_data  = snap_q[rd_addr];
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign core_rst = core_rst_q;

endmodule

// File: tb/tb_a23_run_ctrl.sv
// Directed and randomized run sequences checked against a phase-arithmetic model.
module tb_a23_run_ctrl;

  localparam int unsigned OMS = 4;
  localparam int unsigned WW  = 32;
  localparam int unsigned CCW = 5;
  localparam int unsigned RST = 3;
  localparam int unsigned MCC = 16;
  localparam int CC_MAX = (1 << CCW) - 1;

`ifdef A23_RUN_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              core_terminate = 1'b0;
  logic [OMS*WW-1:0] core_o = '0;
  logic [1:0]        rd_addr = '0;
  logic              busy, done, timeout, core_rst;
  logic [CCW-1:0]    cc;
  logic [WW-1:0]     rd_data;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cur_k = 0;
  logic [WW-1:0] exp_snap [OMS];
  bit          snap_valid = 1'b0;
  bit          exp_tmo = 1'b0;

  a23_run_ctrl #(
    .OUT_MEM_SIZE (OMS),
    .WORD_W       (WW),
    .CC_W         (CCW),
    .RST_CYCLES   (RST),
    .MAX_CC       (MCC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .core_rst       (core_rst),
    .core_terminate (core_terminate),
    .core_o         (core_o),
    .cc             (cc),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > CC_MAX) ? CC_MAX : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s (k=%0d): observed %0h, expected %0h", tag, cur_k, obs, exp);
    end
  endtask

  // One run launched from IDLE; d = RUN cycles before terminate, abort_at < 0 means no abort.
  task automatic run_case(input int d, input int abort_at, input bit hold, input bit junk, input bit fixed);
    int deff, run_last, cap_first, done_k, k_end, ph, j, fin_cc;
    bit tmo, ab;
    logic [WW-1:0] cap_w [OMS];
    logic [OMS*WW-1:0] vec;
    ab        = (abort_at >= 0);
    tmo       = TMO_EN && (d > int'(MCC));
    deff      = tmo ? int'(MCC) : d;
    run_last  = RST + 1 + (ab ? abort_at : deff);
    cap_first = run_last + 1;
    done_k    = cap_first + OMS;
    k_end     = ab ? run_last + 3 : done_k + 3;
    fin_cc    = sat(ab ? abort_at : deff);
    for (int i = 0; i < OMS; i++) cap_w[i] = exp_snap[i];

    cur_k = 0;
    chk("idle_busy", busy, 0);
    chk("idle_tmo", timeout, exp_tmo);
    start = 1'b1;
    abort = 1'b0;
    core_terminate = 1'b0;

    for (int k = 1; k <= k_end; k++) begin
      @(negedge clk);
      cur_k = k;
      j = k - RST - 1;
      if (k <= RST)                 ph = 1;
      else if (k <= run_last)       ph = 2;
      else if (!ab && k < done_k)   ph = 3;
      else if (!ab && k == done_k)  ph = 4;
      else                          ph = 0;

      chk("busy", busy, (ph >= 1 && ph <= 3));
      chk("core_rst", core_rst, (ph == 0 || ph == 1 || ph == 4));
      chk("done", done, (ph == 4));
      chk("cc", cc, (ph == 1) ? 0 : (ph == 2) ? sat(j) : fin_cc);
      chk("timeout", timeout, (ph >= 3 || (ph == 0 && !ab)) ? (!ab && tmo) : 1'b0);

      if (fixed) vec = {32'h44, 32'h33, 32'h22, 32'h11};
      else       vec = {$urandom, $urandom, $urandom, $urandom};
      core_o = vec;
      if (ph == 3) cap_w[k-cap_first] = vec[(k-cap_first)*WW +: WW];

      case (ph)
        1:       core_terminate = 1'($urandom % 2);
        2:       core_terminate = (j >= d);
        3, 4:    core_terminate = 1'($urandom % 2);
        default: core_terminate = 1'b0;
      endcase
      abort = ab && (ph == 2) && (j == abort_at);
      if (hold)                            start = 1'b1;
      else if (junk && ph >= 1 && ph <= 3) start = 1'($urandom % 2);
      else                                 start = 1'b0;
    end

    start = 1'b0;
    abort = 1'b0;
    core_terminate = 1'b0;
    if (!ab) begin
      for (int i = 0; i < OMS; i++) exp_snap[i] = cap_w[i];
      snap_valid = 1'b1;
    end
    exp_tmo = !ab && tmo;
    if (snap_valid) begin
      for (int a = 0; a < OMS; a++) begin
        rd_addr = 2'(a);
        #1;
        chk("rd_data", rd_data, exp_snap[a]);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int d, dmin, ab_at;

    // Reset values
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_cc", cc, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_case(10, -1, 1'b0, 1'b0, 1'b1);
    chk("rd2_is_33", exp_snap[2], 32'h33);
    run_case(0, -1, 1'b0, 1'b0, 1'b0);
    run_case(20, 5, 1'b0, 1'b0, 1'b0);

    // Abort and start together in IDLE: abort wins, held start does not relaunch
    cur_k = 0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("abort_start_busy", busy, 0);
    chk("abort_start_rst", core_rst, 1);
    abort = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("held_start_idle", busy, 0);
    end
    start = 1'b0;
    @(negedge clk);

    run_case(7, -1, 1'b1, 1'b0, 1'b0);
    run_case(12, -1, 1'b0, 1'b1, 1'b0);
    run_case(40, -1, 1'b0, 1'b0, 1'b0);
    run_case(int'(MCC), -1, 1'b0, 1'b0, 1'b0);
    run_case(3, -1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of CAPTURE
    cur_k = 0;
    start = 1'b1;
    for (int k = 1; k <= RST + 3; k++) begin
      @(negedge clk);
      cur_k = k;
      start = 1'b0;
      core_terminate = 1'b1;
    end
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_core_rst", core_rst, 1);
    chk("arst_done", done, 0);
    chk("arst_cc", cc, 0);
    chk("arst_timeout", timeout, 0);
    #1 rst_n = 1'b1;
    core_terminate = 1'b0;
    snap_valid = 1'b0;
    exp_tmo = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end
    run_case(6, -1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      d     = int'($urandom_range(0, 40));
      dmin  = (TMO_EN && d > int'(MCC)) ? int'(MCC) : d;
      ab_at = -1;
      if (dmin > 0 && ($urandom % 4) == 0) ab_at = int'($urandom_range(0, dmin - 1));
      run_case(d, ab_at, 1'($urandom % 2), 1'($urandom % 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
